// File: rtl/video_pipe_sync_pkg.sv
// Shared 640x480 timing constants, memory geometry and pipeline control record
// for the video_pipe_sync slice.
package video_pipe_sync_pkg;

  localparam int          WIDTH     = 640;
  localparam int          HEIGHT    = 480;
  localparam int unsigned MEM_DEPTH = 32'd307200;
  localparam int          CNT_W     = 10;

  localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [CNT_W-1:0] H_FP     = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
  localparam logic [CNT_W-1:0] H_BP     = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [CNT_W-1:0] V_FP     = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
  localparam logic [CNT_W-1:0] V_BP     = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } pix_ctl_t;

  // True while pos lies in the sync pulse [start, start+len).
  function automatic logic in_pulse(input logic [CNT_W-1:0] pos,
                                    input logic [CNT_W-1:0] start,
                                    input logic [CNT_W-1:0] len);
    return (pos >= start) && (pos < (start + len));
  endfunction

endpackage

// File: rtl/video_pipe_sync_sync_gen.sv
// 640x480 raster timing generator: x/y counters with active window and
// active-low sync pulses decoded from the counters.
module video_sync_gen
  import video_pipe_sync_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             hsync,
  output logic             vsync
);

  logic [CNT_W-1:0] x_r;
  logic [CNT_W-1:0] y_r;

  // Raster counters; parked at 0,0 while the pipe is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= 10'd0;
      y_r <= 10'd0;
    end else if (clk_en) begin
      if (!en) begin
        x_r <= 10'd0;
        y_r <= 10'd0;
      end else if (x_r == H_TOTAL - 10'd1) begin
        x_r <= 10'd0;
        y_r <= (y_r == V_TOTAL - 10'd1) ? 10'd0 : y_r + 10'd1;
      end else begin
        x_r <= x_r + 10'd1;
      end
    end
  end

  // Decode visibility and sync pulses from the current position.
  always_comb begin
    x      = x_r;
    y      = y_r;
    active = (x_r < H_ACTIVE) && (y_r < V_ACTIVE);
    hsync  = !in_pulse(x_r, H_ACTIVE + H_FP, H_SYNC);
    vsync  = !in_pulse(y_r, V_ACTIVE + V_FP, V_SYNC);
  end

endmodule

// File: rtl/video_pipe_sync.sv
// Frame-buffer video pipe: timing -> vram read -> grey palette -> output register.
// Build with VIDEO_BORDER_EN defined to include the one-pixel white border.
module video_pipe_sync
  import video_pipe_sync_pkg::*;
#(
  parameter int CW  = 8,
  parameter int MAW = 19,
  parameter int MDW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic           en,
  input  logic           border_en,
  input  logic           vram_clk_en_w,
  input  logic           vram_we,
  input  logic [MAW-1:0] vram_adr_w,
  input  logic [MDW-1:0] vram_dat_w,
  output logic           vid_active,
  output logic           vid_hsync,
  output logic           vid_vsync,
  output logic [CW-1:0]  vid_r,
  output logic [CW-1:0]  vid_g,
  output logic [CW-1:0]  vid_b
);

  logic [CNT_W-1:0] x_s;
  logic [CNT_W-1:0] y_s;
  logic             active_s;
  logic             hsync_s;
  logic             vsync_s;
  logic [MAW-1:0]   rd_addr_s;
  logic [MDW-1:0]   rd_data_r;
  logic [MDW-1:0]   mem [MEM_DEPTH];
  pix_ctl_t         ctl1_r;
  pix_ctl_t         ctl2_r;
  logic             v1_r;
  logic             v2_r;
  logic [CW-1:0]    pal_s;
  logic [CW-1:0]    pal2_r;
  logic             out_active_s;
  logic             out_hsync_s;
  logic             out_vsync_s;
  logic [CW-1:0]    out_rgb_s;

  video_sync_gen u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .en     (en),
    .x      (x_s),
    .y      (y_s),
    .active (active_s),
    .hsync  (hsync_s),
    .vsync  (vsync_s)
  );

  // y*640 + x as shift-add; blanking reads are parked at address 0.
  always_comb begin
    if (active_s) begin
      rd_addr_s = (MAW'(y_s) << 4'd9) + (MAW'(y_s) << 4'd7) + MAW'(x_s);
    end else begin
      rd_addr_s = {MAW{1'b0}};
    end
  end

  // Write port: out-of-range addresses are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (vram_clk_en_w && vram_we && (32'(vram_adr_w) < MEM_DEPTH)) begin
      mem[vram_adr_w] <= vram_dat_w;
    end
  end

  // Synchronous read port; same-address write returns the previous word.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      rd_data_r <= mem[rd_addr_s];
    end
  end

`ifdef VIDEO_BORDER_EN
  logic border1_r;

  // Edge-of-frame flag travels alongside the memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border1_r <= 1'b0;
    end else if (clk_en) begin
      border1_r <= (x_s == 10'd0) || (x_s == H_ACTIVE - 10'd1) ||
                   (y_s == 10'd0) || (y_s == V_ACTIVE - 10'd1);
    end
  end

  // Grey palette with white override on the frame edge.
  always_comb begin
    if (border_en && border1_r) begin
      pal_s = {CW{1'b1}};
    end else begin
      pal_s = CW'(rd_data_r);
    end
  end
`else
  logic unused_border_s;
  assign unused_border_s = border_en;

  // Grey palette: index copied to all components.
  always_comb begin
    pal_s = CW'(rd_data_r);
  end
`endif

  // Stage 1 (read) and stage 2 (palette) control/valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      ctl1_r <= '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};
      ctl2_r <= '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};
      pal2_r <= {CW{1'b0}};
    end else if (clk_en) begin
      v1_r   <= en;
      v2_r   <= v1_r && en;
      ctl1_r <= '{active: active_s, hsync: hsync_s, vsync: vsync_s};
      ctl2_r <= ctl1_r;
      pal2_r <= pal_s;
    end
  end

  // Idle unless a valid pixel reaches the output; RGB blanked outside the window.
  always_comb begin
    out_active_s = 1'b0;
    out_hsync_s  = 1'b1;
    out_vsync_s  = 1'b1;
    out_rgb_s    = {CW{1'b0}};
    if (v2_r && en) begin
      out_active_s = ctl2_r.active;
      out_hsync_s  = ctl2_r.hsync;
      out_vsync_s  = ctl2_r.vsync;
      if (ctl2_r.active) begin
        out_rgb_s = pal2_r;
      end else begin
        out_rgb_s = {CW{1'b0}};
      end
    end else begin
      out_active_s = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_active <= 1'b0;
      vid_hsync  <= 1'b1;
      vid_vsync  <= 1'b1;
      vid_r      <= {CW{1'b0}};
      vid_g      <= {CW{1'b0}};
      vid_b      <= {CW{1'b0}};
    end else if (clk_en) begin
      vid_active <= out_active_s;
      vid_hsync  <= out_hsync_s;
      vid_vsync  <= out_vsync_s;
      vid_r      <= out_rgb_s;
      vid_g      <= out_rgb_s;
      vid_b      <= out_rgb_s;
    end
  end

endmodule

// File: tb/tb_video_pipe_sync.sv
// Directed table-driven bench for video_pipe_sync: pixel probes at known
// clk_en counts after enable, plus reset, stall, border and write sequences.
module tb_video_pipe_sync;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        en;
  logic        border_en;
  logic        vram_clk_en_w;
  logic        vram_we;
  logic [18:0] vram_adr_w;
  logic [7:0]  vram_dat_w;
  logic        vid_active;
  logic        vid_hsync;
  logic        vid_vsync;
  logic [7:0]  vid_r;
  logic [7:0]  vid_g;
  logic [7:0]  vid_b;

  int checks   = 0;
  int failures = 0;

  // k = number of clk_en edges with en high; output shows pixel k-3.
  typedef struct {
    int         pass;
    int         k;
    logic       act;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } vec_t;

  vec_t tbl[$];

  localparam int K_END = 3303;

  video_pipe_sync dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .en            (en),
    .border_en     (border_en),
    .vram_clk_en_w (vram_clk_en_w),
    .vram_we       (vram_we),
    .vram_adr_w    (vram_adr_w),
    .vram_dat_w    (vram_dat_w),
    .vid_active    (vid_active),
    .vid_hsync     (vid_hsync),
    .vid_vsync     (vid_vsync),
    .vid_r         (vid_r),
    .vid_g         (vid_g),
    .vid_b         (vid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input int pass, input int k, input logic act, input logic hs,
                     input logic vs, input logic [7:0] rgb);
    vec_t v;
    v.pass = pass; v.k = k; v.act = act; v.hs = hs; v.vs = vs; v.rgb = rgb;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int k, input logic act,
                               input logic hs, input logic vs, input logic [7:0] rgb);
    check({tag, "_active"}, k, 32'(vid_active), 32'(act));
    check({tag, "_hsync"},  k, 32'(vid_hsync),  32'(hs));
    check({tag, "_vsync"},  k, 32'(vid_vsync),  32'(vs));
    check({tag, "_rgb"},    k, 32'({vid_r, vid_g, vid_b}), 32'({rgb, rgb, rgb}));
  endtask

  task automatic step(input logic ce);
    clk_en = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [18:0] a, input logic [7:0] d);
    vram_clk_en_w = 1'b1;
    vram_we       = 1'b1;
    vram_adr_w    = a;
    vram_dat_w    = d;
    @(posedge clk);
    #1;
    vram_clk_en_w = 1'b0;
    vram_we       = 1'b0;
  endtask

  task automatic compare_k(input int sel, input int k, input string tag);
    foreach (tbl[i]) begin
      if (tbl[i].pass == sel && tbl[i].k == k)
        check_outputs(tag, k, tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].rgb);
    end
  endtask

  task automatic run_pass(input int sel, input logic brd, input bit stretch,
                          input bit wr, input bit pre_idle, input string tag);
    int act_cnt = 0;
    int hs_low  = 0;
    int vs_low  = 0;
    border_en = brd;
    if (pre_idle) begin
      en = 1'b0;
      step(1'b1);
      step(1'b1);
      check_outputs({tag, "_idle"}, 0, 1'b0, 1'b1, 1'b1, 8'h00);
    end
    en = 1'b1;
    for (int k = 1; k <= K_END; k++) begin
      if (wr && k == 100) begin
        vram_clk_en_w = 1'b1;
        vram_we       = 1'b1;
        vram_adr_w    = 19'd641;
        vram_dat_w    = 8'h55;
      end
      if (wr && k == 101) begin
        vram_adr_w    = 19'd307200;
        vram_dat_w    = 8'hAA;
      end
      step(1'b1);
      if (wr && k == 101) begin
        vram_clk_en_w = 1'b0;
        vram_we       = 1'b0;
      end
      if (k >= 3 && k <= 3202) begin
        if (vid_active) act_cnt++;
        if (!vid_hsync) hs_low++;
        if (!vid_vsync) vs_low++;
      end
      compare_k(sel, k, tag);
      if (stretch) begin
        step(1'b0);
        compare_k(sel, k, {tag, "_hold"});
      end
    end
    check({tag, "_active_count"}, K_END, 32'(act_cnt), 32'd2560);
    check({tag, "_hsync_low_count"}, K_END, 32'(hs_low), 32'd384);
    check({tag, "_vsync_low_count"}, K_END, 32'(vs_low), 32'd0);
  endtask

  initial begin
    int bsel;
    logic [7:0] row;

    // Pass 0: plain frame, mem[y*640+x] = y.
    add(0, 2,    1'b0, 1'b1, 1'b1, 8'h00);
    add(0, 3,    1'b1, 1'b1, 1'b1, 8'h00);
    add(0, 4,    1'b1, 1'b1, 1'b1, 8'h00);
    add(0, 642,  1'b1, 1'b1, 1'b1, 8'h00);
    add(0, 643,  1'b0, 1'b1, 1'b1, 8'h00);
    add(0, 658,  1'b0, 1'b1, 1'b1, 8'h00);
    add(0, 659,  1'b0, 1'b0, 1'b1, 8'h00);
    add(0, 754,  1'b0, 1'b0, 1'b1, 8'h00);
    add(0, 755,  1'b0, 1'b1, 1'b1, 8'h00);
    add(0, 802,  1'b0, 1'b1, 1'b1, 8'h00);
    add(0, 803,  1'b1, 1'b1, 1'b1, 8'h01);
    add(0, 804,  1'b1, 1'b1, 1'b1, 8'h01);
    add(0, 1608, 1'b1, 1'b1, 1'b1, 8'h02);
    add(0, 3042, 1'b1, 1'b1, 1'b1, 8'h03);
    add(0, 3303, 1'b1, 1'b1, 1'b1, 8'h04);
    // Pass 1: border on; edge pixels white, interior unchanged.
    add(1, 2,    1'b0, 1'b1, 1'b1, 8'h00);
    add(1, 3,    1'b1, 1'b1, 1'b1, 8'hFF);
    add(1, 4,    1'b1, 1'b1, 1'b1, 8'hFF);
    add(1, 642,  1'b1, 1'b1, 1'b1, 8'hFF);
    add(1, 643,  1'b0, 1'b1, 1'b1, 8'h00);
    add(1, 803,  1'b1, 1'b1, 1'b1, 8'hFF);
    add(1, 804,  1'b1, 1'b1, 1'b1, 8'h01);
    add(1, 1608, 1'b1, 1'b1, 1'b1, 8'h02);
    add(1, 3042, 1'b1, 1'b1, 1'b1, 8'hFF);
    add(1, 3303, 1'b1, 1'b1, 1'b1, 8'h04);
    // Pass 3: 0x55 written to address 641 during row 0.
    add(3, 3,    1'b1, 1'b1, 1'b1, 8'h00);
    add(3, 803,  1'b1, 1'b1, 1'b1, 8'h01);
    add(3, 804,  1'b1, 1'b1, 1'b1, 8'h55);
    add(3, 805,  1'b1, 1'b1, 1'b1, 8'h01);
    add(3, 3303, 1'b1, 1'b1, 1'b1, 8'h04);

    rst_n = 1'b1; clk_en = 1'b0; en = 1'b0; border_en = 1'b0;
    vram_clk_en_w = 1'b0; vram_we = 1'b0; vram_adr_w = 19'd0; vram_dat_w = 8'h00;
    #3 rst_n = 1'b0;
    #4;
    check_outputs("reset", 0, 1'b0, 1'b1, 1'b1, 8'h00);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int y = 0; y < 5; y++) begin
      row = 8'(y);
      for (int x = 0; x < 640; x++) mem_write(19'(y * 640 + x), row);
    end

    run_pass(0, 1'b0, 1'b0, 1'b0, 1'b1, "plain");
`ifdef VIDEO_BORDER_EN
    bsel = 1;
`else
    bsel = 0;
`endif
    run_pass(bsel, 1'b1, 1'b0, 1'b0, 1'b1, "border");
    run_pass(0, 1'b0, 1'b1, 1'b0, 1'b1, "stretch");

    // Mid-line reset: pixel (100,1) is on screen, then everything idles at once.
    border_en = 1'b0;
    en = 1'b0;
    step(1'b1);
    step(1'b1);
    en = 1'b1;
    for (int k = 1; k <= 903; k++) step(1'b1);
    check_outputs("pre_reset", 903, 1'b1, 1'b1, 1'b1, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 903, 1'b0, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_pass(0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");

    run_pass(3, 1'b0, 1'b0, 1'b1, 1'b1, "write");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
